iob_reset_manager: RTL and testbench
====================================

Name: iob_reset_manager

Overview:
- Parametrised reset sequencer for IOb-SoC FPGA wrappers. Generalises the fixed 16-bit power-on reset stretcher into an N-channel manager.
- Synchronises the board reset, stretches it, then releases N_RST active-high resets one after another with a programmable stagger.
- Supports a software-requested reset and reports the cause of the last reset.
- Sits between the board reset pin and the SoC core and peripheral subsystems.

Parameters:
- N_RST, 2, number of reset output channels (1..16).
- CNT_W, 16, stretch/stagger counter width.
- STRETCH, 16'hFFFF, cycles all outputs stay asserted after the synchronised reset deasserts (1..2^CNT_W-1).
- STAGGER, 16, cycles between consecutive channel releases (0 = release all together).
- SYNC_STAGES, 2, resetn synchroniser depth (>=2).
- WDOG_CYCLES, 1000000, watchdog timeout; used only with the optional feature.

Ports:
- clk, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised internally.
- sw_rst_req_i, in, 1, software reset request, level, synchronous to clk.
- wdog_kick_i, in, 1, watchdog kick pulse (ignored when the watchdog is compiled out).
- rst_o, out, N_RST, active-high resets; channel 0 is released first.
- done_o, out, 1, high in RUN (all channels released).
- cause_o, out, 2, last reset cause: 00 pin, 01 software, 10 watchdog.

Behaviour:
- Reset values while resetn is low:
  - rst_o all ones, asynchronously.
  - done_o = 0, cause_o = 00, state = ASSERT.
  - Counter = STRETCH-1, channel index = 0.
- Synchroniser: SYNC_STAGES flops, asynchronously cleared by resetn, shifting in 1. t0 is the first edge at which the synchronised reset reads inactive, i.e. SYNC_STAGES edges after resetn rises.
- ASSERT:
  - Counter decrements each cycle from t0.
  - When the counter reaches 0: rst_o[0] clears on that edge; if N_RST>1 go to RELEASE with index=1 and counter=STAGGER-1, else go to RUN.
  - rst_o[0] therefore falls STRETCH cycles after t0.
- RELEASE:
  - Counter decrements; at 0, clear rst_o[index], increment index and reload counter.
  - After the last channel is cleared, go to RUN.
  - rst_o[k] falls k*STAGGER cycles after rst_o[0].
  - STAGGER=0: all channels clear on the same edge as rst_o[0]; go straight to RUN.
- RUN: done_o=1 and all rst_o=0, registered. done_o rises on the same edge the last channel clears.
- Software reset (sw_rst_req_i=1, sampled each edge, any state):
  - Next edge: all rst_o=1, done_o=0, state ASSERT, counter=STRETCH-1, cause_o=01.
  - While the request is held high, the counter reloads every cycle, extending the reset.
  - Stretching starts the cycle after the request drops.
- resetn low at any time aborts any sequence immediately (async) and restores reset values. resetn dominates sw/watchdog requests.
- rst_o may be cleared only by the sequence above; no glitches. All outputs are registered.
- Counter arithmetic is CNT_W-bit unsigned with no wrap: the reload happens before the counter would underflow.

Optional Feature:
- Macro: IOB_RESET_MANAGER_WDOG_EN.
- With the macro:
  - A watchdog counter runs only in RUN and is cleared on entry to RUN and on wdog_kick_i=1.
  - Reaching WDOG_CYCLES-1 triggers the software-reset path for one cycle, with cause_o=10.
  - If a sw request and a watchdog expiry occur in the same cycle, cause_o=01.
- Without the macro: no watchdog logic, wdog_kick_i is unused, cause_o never reads 10.

Decomposition:
- Package iob_reset_manager_pkg:
  - State encoding: ASSERT=2'd0, RELEASE=2'd1, RUN=2'd2.
  - Cause codes: CAUSE_PIN=2'b00, CAUSE_SW=2'b01, CAUSE_WDOG=2'b10.
- One sub-module, iob_reset_sync: parametrised SYNC_STAGES async-assert/sync-deassert synchroniser, reusable by other wrappers.
- FSM, counters and watchdog stay in the top module.

Test Plan:
- N_RST=3, STRETCH=8, STAGGER=4, SYNC_STAGES=2:
  - Power-on: resetn low 5 cycles, then high -> rst_o=3'b111 until t0+8; bits 0/1/2 fall at t0+8, t0+12, t0+16; done_o rises with bit 2; cause_o=00.
  - STAGGER=0: rst_o goes 3'b111 -> 3'b000 on one edge at t0+8; done_o rises on the same edge.
  - In RUN, sw_rst_req_i high 3 cycles -> rst_o=3'b111 the edge after the first high sample; cause_o=01; rst_o[0] falls 8 cycles after the request drops.
  - resetn pulsed low mid-RELEASE (after bit 0 released) -> rst_o=3'b111 asynchronously within the same cycle; the full sequence restarts; cause_o=00.
- With IOB_RESET_MANAGER_WDOG_EN, WDOG_CYCLES=20:
  - Kick every 10 cycles -> no reset.
  - Stop kicking -> reset 20 cycles after the last kick; cause_o=10.
  - Kick and expiry in the same cycle -> the kick wins.
- Random sw_rst_req_i pulses during ASSERT/RELEASE -> assertion check: rst_o[k] never cleared while rst_o[k-1]=1; done_o implies rst_o=0.

Source files
------------

// File: rtl/iob_reset_manager_pkg.sv
// Shared types and constants for the IOb reset manager and its synchroniser.
package iob_reset_manager_pkg;

  // Sequencer states: hold everything, release channels one by one, running.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Encoding reported on cause_o for the most recent reset.
  localparam logic [1:0] CAUSE_PIN  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;

  // Width of an index that can address channels 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/iob_reset_sync.sv
// Reset synchroniser: assertion is asynchronous, deassertion is delayed by
// SYNC_STAGES clock edges so downstream logic sees a clean release.
module iob_reset_sync #(
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic clk,
  input  logic resetn,
  output logic rst_sync_n_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift a constant one towards the output.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Chain is cleared the instant the board reset asserts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_sync_n_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/iob_reset_manager.sv
// N-channel reset sequencer: synchronises the board reset, stretches it,
// then releases rst_o[0..N_RST-1] in order with a fixed stagger.
// A software request (or the optional watchdog) restarts the sequence and
// cause_o records why the last reset happened.
// Optional watchdog: define IOB_RESET_MANAGER_WDOG_EN to build it in.
module iob_reset_manager
  import iob_reset_manager_pkg::*;
#(
  parameter int unsigned N_RST       = 32'd2,
  parameter int unsigned CNT_W       = 32'd16,
  parameter int unsigned STRETCH     = 32'd65535,
  parameter int unsigned STAGGER     = 32'd16,
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned WDOG_CYCLES = 32'd1000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sw_rst_req_i,
  input  logic             wdog_kick_i,
  output logic [N_RST-1:0] rst_o,
  output logic             done_o,
  output logic [1:0]       cause_o
);

  localparam int unsigned     IDX_W       = idx_width(N_RST);
  localparam logic [CNT_W-1:0] STRETCH_RLD = CNT_W'(STRETCH - 32'd1);
  localparam logic [CNT_W-1:0] STAGGER_RLD = (STAGGER == 32'd0) ? '0 : CNT_W'(STAGGER - 32'd1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_RST - 32'd1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_RST-1:0]   rst_q, rst_d;
  logic               done_q, done_d;
  logic [1:0]         cause_q, cause_d;
  logic               rst_sync_n_s;
  logic               wdog_fire_s;

  iob_reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .resetn       (resetn),
    .rst_sync_n_o (rst_sync_n_s)
  );

`ifdef IOB_RESET_MANAGER_WDOG_EN
  localparam int unsigned     WD_W    = $clog2(WDOG_CYCLES + 32'd1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 32'd1);

  logic [WD_W-1:0] wdog_q, wdog_d;

  // Watchdog counts only while running; a kick in the expiry cycle wins.
  always_comb begin
    wdog_d      = wdog_q;
    wdog_fire_s = 1'b0;
    if ((state_q != RUN) || wdog_kick_i) begin
      wdog_d = '0;
    end else if (wdog_q == WD_LAST) begin
      wdog_d      = '0;
      wdog_fire_s = 1'b1;
    end else begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog_s;

  assign wdog_fire_s   = 1'b0;
  assign unused_wdog_s = wdog_kick_i ^ (WDOG_CYCLES == 32'd0);
`endif

  // Sequencer: restart on request, otherwise stretch then release in order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (sw_rst_req_i || wdog_fire_s) begin
      // Reloading every cycle keeps the reset asserted while the request is held.
      state_d = ASSERT;
      cnt_d   = STRETCH_RLD;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      cause_d = sw_rst_req_i ? CAUSE_SW : CAUSE_WDOG;
    end else if (!rst_sync_n_s) begin
      // Synchronised reset still active: hold the reload values.
      state_d = state_q;
    end else begin
      case (state_q)
        ASSERT: begin
          if (cnt_q == '0) begin
            rst_d[0] = 1'b0;
            if ((N_RST == 32'd1) || (STAGGER == 32'd0)) begin
              rst_d   = '0;
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IDX_W'(1);
              cnt_d   = STAGGER_RLD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == '0) begin
            rst_d[idx_q] = 1'b0;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = STAGGER_RLD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          rst_d  = '0;
          done_d = 1'b1;
        end
        default: begin
          state_d = ASSERT;
          cnt_d   = STRETCH_RLD;
          idx_d   = '0;
          rst_d   = '1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs; board reset forces all resets on.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ASSERT;
      cnt_q   <= STRETCH_RLD;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_PIN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_o   = rst_q;
  assign done_o  = done_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_iob_reset_manager.sv
// Bench for iob_reset_manager: two instances (STAGGER=4 and STAGGER=0) share
// the stimulus. Watchdog sequences run when IOB_RESET_MANAGER_WDOG_EN is set.
module tb_iob_reset_manager;
  import iob_reset_manager_pkg::*;

  localparam int N       = 3;
  localparam int STRETCH = 8;
  localparam int STAGGER = 4;
  localparam int SYNC    = 2;
  localparam int WDOG    = 20;

  logic       clk = 1'b0;
  logic       resetn, sw, kick;
  logic [2:0] rst_a, rst_b;
  logic       done_a, done_b;
  logic [1:0] cause_a, cause_b;

  always #5 clk = ~clk;

  iob_reset_manager #(
    .N_RST(N), .CNT_W(16), .STRETCH(STRETCH), .STAGGER(STAGGER),
    .SYNC_STAGES(SYNC), .WDOG_CYCLES(WDOG)
  ) dut_a (
    .clk(clk), .resetn(resetn), .sw_rst_req_i(sw), .wdog_kick_i(kick),
    .rst_o(rst_a), .done_o(done_a), .cause_o(cause_a)
  );

  iob_reset_manager #(
    .N_RST(N), .CNT_W(16), .STRETCH(STRETCH), .STAGGER(0),
    .SYNC_STAGES(SYNC), .WDOG_CYCLES(WDOG)
  ) dut_b (
    .clk(clk), .resetn(resetn), .sw_rst_req_i(sw), .wdog_kick_i(kick),
    .rst_o(rst_b), .done_o(done_b), .cause_o(cause_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: edges elapsed since the last restart point (t0 or
  // the last sampled sw request) and the cause of that restart.
  int         m_since;
  logic [1:0] m_cause;

  typedef struct {
    logic       rn;
    logic       sw;
    logic [2:0] ra;
    logic       da;
    logic [2:0] rb;
    logic       db;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_rst(input int since, input int stg);
    logic [2:0] r;
    for (int k = 0; k < N; k++) r[k] = (since < STRETCH + k * stg);
    return r;
  endfunction

  function automatic logic m_done(input int since, input int stg);
    return (since >= STRETCH + (N - 1) * stg);
  endfunction

  function automatic void add(input logic rn, input logic s, input logic [2:0] ra, input logic da,
                              input logic [2:0] rb, input logic db, input logic [1:0] c);
    vec_t v;
    v.rn = rn; v.sw = s; v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.cause = c;
    tbl.push_back(v);
  endfunction

  // One clock cycle: drive on the falling edge, sample 1 after the rising edge.
  task automatic step(input logic rn, input logic s, input logic kk);
    @(negedge clk);
    resetn = rn; sw = s; kick = kk;
    @(posedge clk);
    #1;
    if (!rn) begin
      m_since = -SYNC;
      m_cause = CAUSE_PIN;
    end else if (s) begin
      m_since = 0;
      m_cause = CAUSE_SW;
    end else begin
      m_since++;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rst_a"},   rst_a,   m_rst(m_since, STAGGER));
    chk({tag, ".done_a"},  done_a,  m_done(m_since, STAGGER));
    chk({tag, ".rst_b"},   rst_b,   m_rst(m_since, 0));
    chk({tag, ".done_b"},  done_b,  m_done(m_since, 0));
    chk({tag, ".cause_a"}, cause_a, m_cause);
    chk({tag, ".cause_b"}, cause_b, m_cause);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b1; sw = 1'b0; kick = 1'b1;
    m_since = -SYNC; m_cause = CAUSE_PIN;
    #2 resetn = 1'b0;
    #1;
    chk("reset.rst_a", rst_a, 3'b111);
    chk("reset.done_a", done_a, 1'b0);
    chk("reset.cause_a", cause_a, 2'b00);
    chk("reset.rst_b", rst_b, 3'b111);

    // Power-on (t0 = 2nd edge after release), then a 3-cycle sw request.
    for (int i = 0;  i < 5;  i++) add(1'b0, 1'b0, 3'b111, 1'b0, 3'b111, 1'b0, 2'b00);
    for (int i = 5;  i < 14; i++) add(1'b1, 1'b0, 3'b111, 1'b0, 3'b111, 1'b0, 2'b00);
    for (int i = 14; i < 18; i++) add(1'b1, 1'b0, 3'b110, 1'b0, 3'b000, 1'b1, 2'b00);
    for (int i = 18; i < 22; i++) add(1'b1, 1'b0, 3'b100, 1'b0, 3'b000, 1'b1, 2'b00);
    for (int i = 22; i < 26; i++) add(1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 2'b00);
    for (int i = 26; i < 29; i++) add(1'b1, 1'b1, 3'b111, 1'b0, 3'b111, 1'b0, 2'b01);
    for (int i = 29; i < 36; i++) add(1'b1, 1'b0, 3'b111, 1'b0, 3'b111, 1'b0, 2'b01);
    for (int i = 36; i < 40; i++) add(1'b1, 1'b0, 3'b110, 1'b0, 3'b000, 1'b1, 2'b01);
    for (int i = 40; i < 44; i++) add(1'b1, 1'b0, 3'b100, 1'b0, 3'b000, 1'b1, 2'b01);
    for (int i = 44; i < 48; i++) add(1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 2'b01);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rn, tbl[i].sw, 1'b1);
      chk($sformatf("tbl%0d.rst_a", i),   rst_a,   tbl[i].ra);
      chk($sformatf("tbl%0d.done_a", i),  done_a,  tbl[i].da);
      chk($sformatf("tbl%0d.rst_b", i),   rst_b,   tbl[i].rb);
      chk($sformatf("tbl%0d.done_b", i),  done_b,  tbl[i].db);
      chk($sformatf("tbl%0d.cause_a", i), cause_a, tbl[i].cause);
      chk($sformatf("tbl%0d.cause_b", i), cause_b, tbl[i].cause);
    end

    // Board reset pulsed mid-RELEASE: outputs must return to reset at once.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1);
    chk("midrel.pre_rst_a", rst_a, 3'b110);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrel.async_rst_a", rst_a, 3'b111);
    chk("midrel.async_rst_b", rst_b, 3'b111);
    chk("midrel.async_done_b", done_b, 1'b0);
    chk("midrel.async_cause_a", cause_a, CAUSE_PIN);
    m_since = -SYNC; m_cause = CAUSE_PIN;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk_model("restart");
    end

    // Random sw requests, alternating busy and quiet phases.
    for (int i = 0; i < 400; i++) begin
      logic s;
      s = ($urandom_range(0, 99) < (((i / 50) % 2 == 1) ? 3 : 15));
      step(1'b1, s, 1'b1);
      chk_model("rand");
      for (int k = 1; k < N; k++) begin
        chk("rand.order_a", (rst_a[k-1] && !rst_a[k]), 1'b0);
      end
      chk("rand.done_zero_a", (done_a && (rst_a != 3'b000)), 1'b0);
      chk("rand.done_zero_b", (done_b && (rst_b != 3'b000)), 1'b0);
    end

`ifdef IOB_RESET_MANAGER_WDOG_EN
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk_model("wd.settle");
    end
    // Regular kicks keep both instances running.
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b0, (i % 10 == 0));
      chk("wd.kicked_a", rst_a, 3'b000);
      chk("wd.kicked_b", rst_b, 3'b000);
    end
    // A kick landing in the expiry cycle suppresses the reset.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, (i == 20));
      chk("wd.collide_a", rst_a, 3'b000);
      chk("wd.collide_b", rst_b, 3'b000);
    end
    // No more kicks: reset 20 cycles after the last one.
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("wd.wait_a", rst_a, 3'b000);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("wd.fire_rst_a", rst_a, 3'b111);
    chk("wd.fire_rst_b", rst_b, 3'b111);
    chk("wd.fire_done_a", done_a, 1'b0);
    chk("wd.fire_cause_a", cause_a, CAUSE_WDOG);
    chk("wd.fire_cause_b", cause_b, CAUSE_WDOG);
    m_since = 0; m_cause = CAUSE_WDOG;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk_model("wd.after");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
